mor1kx_tlb_reload_arb: RTL and testbench



---
 rtl/mor1kx_tlb_reload_pkg.sv | 18 +
 rtl/mor1kx_tlb_reload_arb.sv | 149 ++++++++++++++
 tb/tb_mor1kx_tlb_reload_arb.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mor1kx_tlb_reload_pkg.sv
// Shared encodings for the TLB-reload page-table port arbiter.
package mor1kx_tlb_reload_pkg;

  localparam int unsigned TMO_W = 16;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IMMU = 2'd1,
    OWNER_DMMU = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/mor1kx_tlb_reload_arb.sv
// Shares one page-table read port between the IMMU and DMMU reload walkers,
// locking it to one walker per walk, with per-access timeout and error return.
module mor1kx_tlb_reload_arb
  import mor1kx_tlb_reload_pkg::*;
#(
  parameter int unsigned OPTION_OPERAND_WIDTH  = 32,
  parameter int unsigned OPTION_RELOAD_TIMEOUT = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            immu_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
  input  logic                            immu_busy_i,
  output logic                            immu_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] immu_data_o,
  output logic                            immu_err_o,
  input  logic                            dmmu_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
  input  logic                            dmmu_busy_i,
  output logic                            dmmu_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] dmmu_data_o,
  output logic                            dmmu_err_o,
  output logic                            mem_req_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] mem_addr_o,
  input  logic                            mem_ack_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] mem_data_i,
  input  logic                            mem_err_i,
  output logic [1:0]                      owner_o
);

  localparam int unsigned W = OPTION_OPERAND_WIDTH;
  localparam bit TMO_EN = (OPTION_RELOAD_TIMEOUT != 0);
  // Counter reads 0 in the first ISSUE cycle, so the T-th cycle sees T-1.
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((OPTION_RELOAD_TIMEOUT == 0) ? 0 : OPTION_RELOAD_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic             mem_req_q, mem_req_d;
  logic [W-1:0]     mem_addr_q, mem_addr_d;
  logic             last_dmmu_q, last_dmmu_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic             grant_dmmu;
  logic             own_req;
  logic             own_busy;
  logic [W-1:0]     own_addr;
  logic             fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_NONE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      last_dmmu_q <= 1'b1;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      last_dmmu_q <= last_dmmu_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    last_dmmu_d = last_dmmu_q;
    tmo_d       = tmo_q;
    immu_ack_o  = 1'b0;
    immu_err_o  = 1'b0;
    immu_data_o = '0;
    dmmu_ack_o  = 1'b0;
    dmmu_err_o  = 1'b0;
    dmmu_data_o = '0;
    grant_dmmu  = 1'b0;
    fail        = 1'b0;
    own_req     = (owner_q == OWNER_DMMU) ? dmmu_req_i  : immu_req_i;
    own_busy    = (owner_q == OWNER_DMMU) ? dmmu_busy_i : immu_busy_i;
    own_addr    = (owner_q == OWNER_DMMU) ? dmmu_addr_i : immu_addr_i;

    case (state_q)
      IDLE: begin
        if (immu_req_i || dmmu_req_i) begin
          // Round-robin: DMMU wins a tie only if IMMU was granted last.
          grant_dmmu  = dmmu_req_i && (!immu_req_i || !last_dmmu_q);
          owner_d     = grant_dmmu ? OWNER_DMMU : OWNER_IMMU;
          last_dmmu_d = grant_dmmu;
          mem_addr_d  = grant_dmmu ? dmmu_addr_i : immu_addr_i;
          mem_req_d   = 1'b1;
          tmo_d       = '0;
          state_d     = ISSUE;
        end
      end

      ISSUE: begin
        fail = mem_err_i || (!mem_ack_i && TMO_EN && (tmo_q == TMO_LAST));
        if (fail) begin
          immu_err_o = (owner_q == OWNER_IMMU);
          dmmu_err_o = (owner_q == OWNER_DMMU);
          mem_req_d  = 1'b0;
          owner_d    = OWNER_NONE;
          state_d    = IDLE;
        end else if (mem_ack_i) begin
          if (owner_q == OWNER_DMMU) begin
            dmmu_ack_o  = 1'b1;
            dmmu_data_o = mem_data_i;
          end else begin
            immu_ack_o  = 1'b1;
            immu_data_o = mem_data_i;
          end
          mem_req_d = 1'b0;
          state_d   = HOLD;
        end else if (tmo_q != TMO_MAX) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      HOLD: begin
        if (own_req) begin
          mem_addr_d = own_addr;
          mem_req_d  = 1'b1;
          tmo_d      = '0;
          state_d    = ISSUE;
        end else if (!own_busy) begin
          owner_d = OWNER_NONE;
          state_d = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        owner_d   = OWNER_NONE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;
  assign owner_o    = owner_q;

endmodule

// File: tb/tb_mor1kx_tlb_reload_arb.sv
// Directed bench for the TLB-reload arbiter: vector table plus timeout/reset sequences.
module tb_mor1kx_tlb_reload_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance (default timeout)
  logic        immu_req, immu_busy, dmmu_req, dmmu_busy, mem_ack, mem_err;
  logic [31:0] immu_addr, dmmu_addr, mem_data;
  logic        immu_ack, immu_err, dmmu_ack, dmmu_err, mem_req;
  logic [31:0] immu_data, dmmu_data, mem_addr;
  logic [1:0]  owner;

  // Shared stimulus for the T=4 and T=0 instances
  logic        b_immu_req, b_immu_busy, b_mem_ack;
  logic [31:0] b_immu_addr, b_mem_data;
  logic        t4_immu_ack, t4_immu_err, t4_dmmu_ack, t4_dmmu_err, t4_mem_req;
  logic [31:0] t4_immu_data, t4_dmmu_data, t4_mem_addr;
  logic [1:0]  t4_owner;
  logic        t0_immu_ack, t0_immu_err, t0_dmmu_ack, t0_dmmu_err, t0_mem_req;
  logic [31:0] t0_immu_data, t0_dmmu_data, t0_mem_addr;
  logic [1:0]  t0_owner;

  mor1kx_tlb_reload_arb dut (
    .clk(clk), .rst_n(rst_n),
    .immu_req_i(immu_req), .immu_addr_i(immu_addr), .immu_busy_i(immu_busy),
    .immu_ack_o(immu_ack), .immu_data_o(immu_data), .immu_err_o(immu_err),
    .dmmu_req_i(dmmu_req), .dmmu_addr_i(dmmu_addr), .dmmu_busy_i(dmmu_busy),
    .dmmu_ack_o(dmmu_ack), .dmmu_data_o(dmmu_data), .dmmu_err_o(dmmu_err),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack),
    .mem_data_i(mem_data), .mem_err_i(mem_err), .owner_o(owner)
  );

  mor1kx_tlb_reload_arb #(.OPTION_OPERAND_WIDTH(32), .OPTION_RELOAD_TIMEOUT(4)) dut_t4 (
    .clk(clk), .rst_n(rst_n),
    .immu_req_i(b_immu_req), .immu_addr_i(b_immu_addr), .immu_busy_i(b_immu_busy),
    .immu_ack_o(t4_immu_ack), .immu_data_o(t4_immu_data), .immu_err_o(t4_immu_err),
    .dmmu_req_i(1'b0), .dmmu_addr_i(32'h0), .dmmu_busy_i(1'b0),
    .dmmu_ack_o(t4_dmmu_ack), .dmmu_data_o(t4_dmmu_data), .dmmu_err_o(t4_dmmu_err),
    .mem_req_o(t4_mem_req), .mem_addr_o(t4_mem_addr), .mem_ack_i(b_mem_ack),
    .mem_data_i(b_mem_data), .mem_err_i(1'b0), .owner_o(t4_owner)
  );

  mor1kx_tlb_reload_arb #(.OPTION_OPERAND_WIDTH(32), .OPTION_RELOAD_TIMEOUT(0)) dut_t0 (
    .clk(clk), .rst_n(rst_n),
    .immu_req_i(b_immu_req), .immu_addr_i(b_immu_addr), .immu_busy_i(b_immu_busy),
    .immu_ack_o(t0_immu_ack), .immu_data_o(t0_immu_data), .immu_err_o(t0_immu_err),
    .dmmu_req_i(1'b0), .dmmu_addr_i(32'h0), .dmmu_busy_i(1'b0),
    .dmmu_ack_o(t0_dmmu_ack), .dmmu_data_o(t0_dmmu_data), .dmmu_err_o(t0_dmmu_err),
    .mem_req_o(t0_mem_req), .mem_addr_o(t0_mem_addr), .mem_ack_i(b_mem_ack),
    .mem_data_i(b_mem_data), .mem_err_i(1'b0), .owner_o(t0_owner)
  );

  // in = {immu_req, immu_busy, dmmu_req, dmmu_busy, mem_ack, mem_err}
  // ex = {mem_req, immu_ack, immu_err, dmmu_ack, dmmu_err}
  typedef struct {
    logic        rst;
    logic [5:0]  in;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] md;
    logic [4:0]  ex;
    logic [31:0] ea;
    logic [1:0]  eo;
    logic [31:0] eid;
    logic [31:0] edd;
  } vec_t;

  vec_t vq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {immu_req, immu_busy, dmmu_req, dmmu_busy, mem_ack, mem_err} = 6'b0;
    immu_addr = 32'h0; dmmu_addr = 32'h0; mem_data = 32'h0;
    b_immu_req = 1'b0; b_immu_busy = 1'b0; b_mem_ack = 1'b0;
    b_immu_addr = 32'h0; b_mem_data = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic apply(input int idx, input vec_t v);
    if (v.rst) do_reset();
    @(negedge clk);
    {immu_req, immu_busy, dmmu_req, dmmu_busy, mem_ack, mem_err} = v.in;
    immu_addr = v.ia; dmmu_addr = v.da; mem_data = v.md;
    #1;
    chk($sformatf("row%0d.mem_req", idx),   32'(mem_req),   32'(v.ex[4]));
    chk($sformatf("row%0d.immu_ack", idx),  32'(immu_ack),  32'(v.ex[3]));
    chk($sformatf("row%0d.immu_err", idx),  32'(immu_err),  32'(v.ex[2]));
    chk($sformatf("row%0d.dmmu_ack", idx),  32'(dmmu_ack),  32'(v.ex[1]));
    chk($sformatf("row%0d.dmmu_err", idx),  32'(dmmu_err),  32'(v.ex[0]));
    chk($sformatf("row%0d.owner", idx),     32'(owner),     32'(v.eo));
    chk($sformatf("row%0d.immu_data", idx), immu_data, v.eid);
    chk($sformatf("row%0d.dmmu_data", idx), dmmu_data, v.edd);
    if (v.ex[4] || v.rst) chk($sformatf("row%0d.mem_addr", idx), mem_addr, v.ea);
  endtask

  initial begin
    int bad;
    rst_n = 1'b1;
    //                 rst   in          ia            da            md            ex        ea            eo    eid           edd
    // IMMU-only walk: 3-cycle access, reissue, release
    vq.push_back(vec_t'{1'b1, 6'b000000, 32'h0,        32'h0,        32'h0,        5'b00000, 32'h0,        2'd0, 32'h0,        32'h0});
    vq.push_back(vec_t'{1'b0, 6'b110000, 32'h00001000, 32'h0,        32'h0,        5'b00000, 32'h0,        2'd0, 32'h0,        32'h0});
    vq.push_back(vec_t'{1'b0, 6'b110000, 32'h00001000, 32'h0,        32'h0,        5'b10000, 32'h00001000, 2'd1, 32'h0,        32'h0});
    vq.push_back(vec_t'{1'b0, 6'b110000, 32'h00001000, 32'h0,        32'h0,        5'b10000, 32'h00001000, 2'd1, 32'h0,        32'h0});
    vq.push_back(vec_t'{1'b0, 6'b110010, 32'h00001000, 32'h0,        32'hABCDE000, 5'b11000, 32'h00001000, 2'd1, 32'hABCDE000, 32'h0});
    vq.push_back(vec_t'{1'b0, 6'b110000, 32'hABCDE3FC, 32'h0,        32'h0,        5'b00000, 32'h0,        2'd1, 32'h0,        32'h0});
    vq.push_back(vec_t'{1'b0, 6'b110010, 32'hABCDE3FC, 32'h0,        32'h12345678, 5'b11000, 32'hABCDE3FC, 2'd1, 32'h12345678, 32'h0});
    vq.push_back(vec_t'{1'b0, 6'b010000, 32'h0,        32'h0,        32'h0,        5'b00000, 32'h0,        2'd1, 32'h0,        32'h0});
    vq.push_back(vec_t'{1'b0, 6'b000000, 32'h0,        32'h0,        32'h0,        5'b00000, 32'h0,        2'd1, 32'h0,        32'h0});
    vq.push_back(vec_t'{1'b0, 6'b000010, 32'h0,        32'h0,        32'hDEADBEEF, 5'b00000, 32'h0,        2'd0, 32'h0,        32'h0});
    // Tie after reset, lock while DMMU waits, handover, err beats ack, round-robin
    vq.push_back(vec_t'{1'b1, 6'b111100, 32'h00002000, 32'h00003000, 32'h0,        5'b00000, 32'h0,        2'd0, 32'h0,        32'h0});
    vq.push_back(vec_t'{1'b0, 6'b111110, 32'h00002000, 32'h00003000, 32'h11110000, 5'b11000, 32'h00002000, 2'd1, 32'h11110000, 32'h0});
    vq.push_back(vec_t'{1'b0, 6'b011110, 32'h0,        32'h00003000, 32'h22220000, 5'b00000, 32'h0,        2'd1, 32'h0,        32'h0});
    vq.push_back(vec_t'{1'b0, 6'b001100, 32'h0,        32'h00003000, 32'h0,        5'b00000, 32'h0,        2'd1, 32'h0,        32'h0});
    vq.push_back(vec_t'{1'b0, 6'b001100, 32'h0,        32'h00003000, 32'h0,        5'b00000, 32'h0,        2'd0, 32'h0,        32'h0});
    vq.push_back(vec_t'{1'b0, 6'b001111, 32'h0,        32'h00003000, 32'h0,        5'b10001, 32'h00003000, 2'd2, 32'h0,        32'h0});
    vq.push_back(vec_t'{1'b0, 6'b111100, 32'h00004000, 32'h00003000, 32'h0,        5'b00000, 32'h0,        2'd0, 32'h0,        32'h0});
    vq.push_back(vec_t'{1'b0, 6'b111110, 32'h00004000, 32'h00003000, 32'h5555AAAA, 5'b11000, 32'h00004000, 2'd1, 32'h5555AAAA, 32'h0});
    vq.push_back(vec_t'{1'b0, 6'b001100, 32'h0,        32'h00003000, 32'h0,        5'b00000, 32'h0,        2'd1, 32'h0,        32'h0});
    vq.push_back(vec_t'{1'b0, 6'b001100, 32'h0,        32'h00003000, 32'h0,        5'b00000, 32'h0,        2'd0, 32'h0,        32'h0});
    vq.push_back(vec_t'{1'b0, 6'b001110, 32'h0,        32'h00003000, 32'h0BADF00D, 5'b10010, 32'h00003000, 2'd2, 32'h0,        32'h0BADF00D});
    vq.push_back(vec_t'{1'b0, 6'b000000, 32'h0,        32'h0,        32'h0,        5'b00000, 32'h0,        2'd2, 32'h0,        32'h0});
    vq.push_back(vec_t'{1'b0, 6'b000000, 32'h0,        32'h0,        32'h0,        5'b00000, 32'h0,        2'd0, 32'h0,        32'h0});

    for (int i = 0; i < vq.size(); i++) apply(i, vq[i]);

    // Reset asserted mid-access, then a late ack
    do_reset();
    @(negedge clk);
    immu_req = 1'b1; immu_busy = 1'b1; immu_addr = 32'h00006000;
    @(negedge clk); #1;
    chk("rst_mid.pre_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid.owner", 32'(owner), 32'd0);
    chk("rst_mid.mem_addr", mem_addr, 32'h0);
    mem_ack = 1'b1; mem_data = 32'hFEEDFACE;
    #1;
    chk("rst_mid.immu_ack", 32'(immu_ack), 32'd0);
    chk("rst_mid.immu_data", immu_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; immu_req = 1'b0; immu_busy = 1'b0;
    #1;
    chk("rst_late.immu_ack", 32'(immu_ack), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("rst_late.mem_req", 32'(mem_req), 32'd0);
    chk("rst_late.owner", 32'(owner), 32'd0);

    // Timeout: T=4 errors in the 4th ISSUE cycle; T=0 never times out
    do_reset();
    @(negedge clk);
    b_immu_req = 1'b1; b_immu_busy = 1'b1; b_immu_addr = 32'h00007000;
    #1;
    chk("tmo.idle_req", 32'(t4_mem_req), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      chk($sformatf("tmo.c%0d.t4_req", k), 32'(t4_mem_req), 32'd1);
      chk($sformatf("tmo.c%0d.t4_err", k), 32'(t4_immu_err), 32'(k == 4));
      chk($sformatf("tmo.c%0d.t0_err", k), 32'(t0_immu_err), 32'd0);
    end
    b_immu_req = 1'b0; b_immu_busy = 1'b0;
    @(negedge clk); #1;
    chk("tmo.t4_req_after", 32'(t4_mem_req), 32'd0);
    chk("tmo.t4_owner_after", 32'(t4_owner), 32'd0);
    chk("tmo.t0_still_req", 32'(t0_mem_req), 32'd1);
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk); #1;
      if (t0_immu_err || !t0_mem_req) bad++;
    end
    chk("tmo.t0_no_timeout", 32'(bad), 32'd0);
    @(negedge clk);
    b_mem_ack = 1'b1; b_mem_data = 32'hC0FFEE00;
    #1;
    chk("tmo.t0_ack", 32'(t0_immu_ack), 32'd1);
    chk("tmo.t0_data", t0_immu_data, 32'hC0FFEE00);
    chk("tmo.t4_idle_ack", 32'(t4_immu_ack), 32'd0);
    @(negedge clk);
    b_mem_ack = 1'b0;
    // Ack in the 4th ISSUE cycle beats the timeout
    @(negedge clk);
    b_immu_req = 1'b1; b_immu_busy = 1'b1; b_immu_addr = 32'h00007100;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      chk($sformatf("tmo2.c%0d.t4_err", k), 32'(t4_immu_err), 32'd0);
    end
    @(negedge clk);
    b_mem_ack = 1'b1; b_mem_data = 32'h00004444;
    #1;
    chk("tmo2.t4_ack", 32'(t4_immu_ack), 32'd1);
    chk("tmo2.t4_err", 32'(t4_immu_err), 32'd0);
    chk("tmo2.t4_addr", t4_mem_addr, 32'h00007100);
    @(negedge clk);
    b_mem_ack = 1'b0; b_immu_req = 1'b0; b_immu_busy = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
